// File: rtl/aes_stream_ctrl.sv
// Streaming valid/ready wrapper around a non-stallable pipelined AES core: key-load FSM,
// in-flight tag tracking and a credit-gated FWFT result FIFO. Optional counters: AES_STREAM_STATS_EN.
module aes_stream_ctrl #(
  parameter int DATA_W        = 128,
  parameter int KEY_W         = 128,
  parameter int KEYGEN_CYCLES = 10,
  parameter int PIPE_LAT      = 11,
  parameter int FIFO_DEPTH    = 16,
  parameter int TAG_W         = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [KEY_W-1:0]  key_in,
  input  logic              key_load,
  output logic              key_load_ready,
  output logic              key_ready,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [TAG_W-1:0]  out_tag,
  output logic [KEY_W-1:0]  core_key,
  output logic              core_fsm_en,
  output logic [DATA_W-1:0] core_in,
  output logic              core_enable,
  input  logic [DATA_W-1:0] core_out
`ifdef AES_STREAM_STATS_EN
  ,
  output logic [31:0]       blk_in_cnt,
  output logic [31:0]       blk_out_cnt
`endif
);

  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = AW + 1;
  localparam int KCW = $clog2(KEYGEN_CYCLES + 2);

  typedef enum logic [1:0] {NO_KEY, KEYGEN, READY} state_t;

  state_t            state_q, state_d;
  logic [KCW-1:0]    kg_cnt_q;
  logic              kl_ready;
  logic              key_load_accept;
  logic [CW-1:0]     inflight_q;
  logic [CW-1:0]     fifo_cnt_q;
  logic [CW:0]       credit_sum;
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic              push, pop;

  logic [PIPE_LAT-1:0] vld_p;
  logic [TAG_W-1:0]    tag_p    [PIPE_LAT];
  logic [DATA_W-1:0]   mem_data [FIFO_DEPTH];
  logic [TAG_W-1:0]    mem_tag  [FIFO_DEPTH];

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Key-load FSM
  always_comb begin
    state_d     = state_q;
    kl_ready    = 1'b0;
    key_ready   = 1'b0;
    core_fsm_en = 1'b0;
    case (state_q)
      NO_KEY: begin
        kl_ready = 1'b1;
        if (key_load) state_d = KEYGEN;
      end
      KEYGEN: begin
        core_fsm_en = (kg_cnt_q == KCW'(KEYGEN_CYCLES));
        if (kg_cnt_q == '0) state_d = READY;
      end
      READY: begin
        key_ready = 1'b1;
        // Rekeying under live traffic would mix keys inside the core pipeline.
        kl_ready  = (inflight_q == '0);
        if (key_load && kl_ready) state_d = KEYGEN;
      end
      default: state_d = NO_KEY;
    endcase
  end

  // During reset every output reads 0, including the NO_KEY load-ready strobe.
  assign key_load_ready  = kl_ready & rst;
  assign key_load_accept = key_load & key_load_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= NO_KEY;
      kg_cnt_q <= '0;
      core_key <= '0;
    end else begin
      state_q <= state_d;
      if (key_load_accept) begin
        kg_cnt_q <= KCW'(KEYGEN_CYCLES);
        core_key <= key_in;
      end else if (state_q == KEYGEN && kg_cnt_q != '0) begin
        kg_cnt_q <= kg_cnt_q - 1'b1;
      end
    end
  end

  // Credit-gated acceptance; credits come from registered counts only
  assign credit_sum  = {1'b0, inflight_q} + {1'b0, fifo_cnt_q};
  assign in_ready    = (state_q == READY) & (credit_sum < (CW+1)'(FIFO_DEPTH)) & ~key_load_accept;
  assign core_enable = in_valid & in_ready;
  assign core_in     = in_data & {DATA_W{rst}};

  // Tracking stages p0..p(PIPE_LAT-1), last stage aligned with core_out
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p <= '0;
    end else begin
      vld_p[0] <= core_enable;
      for (int i = 1; i < PIPE_LAT; i++) vld_p[i] <= vld_p[i-1];
    end
  end

  always_ff @(posedge clk) begin
    tag_p[0] <= in_tag;
    for (int i = 1; i < PIPE_LAT; i++) tag_p[i] <= tag_p[i-1];
  end

  assign push = vld_p[PIPE_LAT-1];
  assign pop  = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inflight_q <= '0;
    end else if (core_enable && !push) begin
      inflight_q <= inflight_q + 1'b1;
    end else if (push && !core_enable) begin
      inflight_q <= inflight_q - 1'b1;
    end
  end

  // Result FIFO, first-word-fall-through
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr_q] <= core_out;
      mem_tag[wr_ptr_q]  <= tag_p[PIPE_LAT-1];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      fifo_cnt_q <= fifo_cnt_q + 1'b1;
      else if (pop && !push) fifo_cnt_q <= fifo_cnt_q - 1'b1;
    end
  end

  assign out_valid = (fifo_cnt_q != '0);
  assign out_data  = out_valid ? mem_data[rd_ptr_q] : '0;
  assign out_tag   = out_valid ? mem_tag[rd_ptr_q]  : '0;

`ifdef AES_STREAM_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      blk_in_cnt  <= '0;
      blk_out_cnt <= '0;
    end else begin
      if (core_enable) blk_in_cnt  <= sat_inc(blk_in_cnt);
      if (pop)         blk_out_cnt <= sat_inc(blk_out_cnt);
    end
  end
`endif

endmodule

// File: doc/aes_stream_ctrl.md
Name: aes_stream_ctrl

Overview:
Streaming front-end and back-end around the existing pipelined AES encryption core (AES_enc: IN/KEY/enable/fsm_en/OUT).
- Replaces the manual "pulse fsm_en, then wait out key expansion" sequence with a key-load state machine.
- Adds valid/ready handshakes and per-block tags.
- Tracks blocks in flight with a valid/tag shift register.
- Buffers results in an output FIFO with credit-based flow control, because the core pipeline cannot stall.

Parameters:
DATA_W, 128, block width (core IN/OUT)
KEY_W, 128, key width passed to core (128 or 256)
KEYGEN_CYCLES, 10, cycles from the core_fsm_en pulse until round keys are valid
PIPE_LAT, 11, core latency in cycles from core_enable to matching core_out
FIFO_DEPTH, 16, output FIFO entries (power of two, >= 2)
TAG_W, 4, user tag width carried alongside each block

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
key_in  in  KEY_W  key, sampled on key_load & key_load_ready
key_load  in  1  key load request
key_load_ready  out  1  key load may be accepted this cycle
key_ready  out  1  round keys valid; streaming allowed
in_valid  in  1  input block valid
in_ready  out  1  input block accepted when in_valid & in_ready
in_data  in  DATA_W  plaintext
in_tag  in  TAG_W  user tag
out_valid  out  1  result valid
out_ready  in  1  consumer accepts
out_data  out  DATA_W  ciphertext
out_tag  out  TAG_W  tag of the block
core_key  out  KEY_W  to core KEY (registered)
core_fsm_en  out  1  to core fsm_en
core_in  out  DATA_W  to core IN
core_enable  out  1  to core enable
core_out  in  DATA_W  from core OUT

Behaviour:
- Reset (rst=0, async): FSM=NO_KEY; all outputs 0; core_key=0; shift register, FIFO, counters and credit count cleared.
- FSM states: NO_KEY, KEYGEN, READY.
  - NO_KEY: key_load_ready=1; on key_load, register key_in into core_key and go to KEYGEN.
  - KEYGEN: core_fsm_en=1 in the first KEYGEN cycle only. A down-counter starts at KEYGEN_CYCLES; on reaching 0, go to READY. key_load_ready=0.
  - READY: key_ready=1. key_load_ready=1 only when inflight==0. A key_load accepted in READY re-registers the key, drops key_ready and goes to KEYGEN. FIFO contents are kept and drain normally.
- Input acceptance:
  - in_ready = (state==READY) & (inflight + fifo_count < FIFO_DEPTH) & ~key_load_accept.
  - A FIFO pop in the same cycle does not free a credit until the next cycle.
- Core drive (combinational): core_in = in_data; core_enable = in_valid & in_ready.
- Tracking: a PIPE_LAT-deep shift register of {valid, tag}. Stage 0 loads on every clock with {core_enable, in_tag}. The last stage is aligned with core_out. When the last stage is valid, {core_out, tag} is written to the FIFO on that edge.
- Latency: with the FIFO empty and out_ready=1, out_valid is asserted PIPE_LAT+1 cycles after the accepting edge. Steady-state throughput is 1 block/cycle.
- inflight: a counter of valid shift-register stages, +1 on accept and -1 on FIFO write. Simultaneous accept and write leaves it unchanged.
- FIFO:
  - First-word-fall-through: out_valid = ~empty, with out_data/out_tag at the head.
  - Pop on out_valid & out_ready.
  - Simultaneous push and pop when full or empty is legal; count is unchanged.
  - Credit gating guarantees a push never occurs when full. Overflow is unreachable by construction.
  - Pointers wrap modulo FIFO_DEPTH.
- Ordering: outputs leave strictly in acceptance order, with tags unchanged.
- Reset mid-operation: in-flight blocks and FIFO data are discarded. A key reload is required after reset.

Optional Feature:
AES_STREAM_STATS_EN
- Defined: adds output ports blk_in_cnt[31:0] and blk_out_cnt[31:0].
  - blk_in_cnt counts accepted input handshakes; blk_out_cnt counts output handshakes.
  - Both counters saturate at 0xFFFFFFFF and are reset to 0.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
1. Key load: key_in=000102030405060708090A0B0C0D0E0F with a key_load pulse.
   - core_fsm_en is high for exactly 1 cycle.
   - key_ready rises KEYGEN_CYCLES+1 cycles after the load edge.
   - in_ready stays 0 until key_ready is high.
2. Back-to-back: 11 blocks with tags 0..10, in_valid=1 continuously, out_ready=1.
   - First output is 69C4E0D86A7B0430D8CDB78070B4C55A with tag 0, PIPE_LAT+1 cycles after the first accept.
   - Plaintext 00000000000000000000000000000000 gives C6A13B37878F5B826F4F8162A1C8D879.
   - Plaintext CCCCCCCCCCCCCCCCCCCCCCCCCCCCCCCC gives AEB05C6BB162066E45E078946DB82C7F (tag 10).
   - The 11 outputs appear on consecutive cycles.
3. Backpressure: out_ready=0 while offering 20 blocks.
   - Exactly 16 are accepted, then in_ready=0.
   - Raising out_ready drains 16 blocks in order, and in_ready returns the cycle after the first pop.
4. Rekey guard: key_load asserted while inflight>0.
   - key_load_ready=0 and the request is held off until the pipeline empties.
   - The request is then accepted, key_ready drops, and results already in the FIFO are still delivered.
5. Reset mid-stream: rst=0 with 5 blocks in flight.
   - All outputs go to 0 immediately; after rst=1, out_valid=0 and key_ready=0.
6. With AES_STREAM_STATS_EN defined, after scenario 2:
   - blk_in_cnt=11 and blk_out_cnt=11.
   - Both counters are 0 after reset.
